simple_dma_controller: RTL and testbench
========================================

Name: simple_dma_controller

Overview:
- Bus-master stage directly downstream of the simple DMA device peripheral.
- Takes the device's request bundle (start address, word count, direction) and runs word transfers over the openMSP430 DMA memory port.
- Returns per-word acknowledge and data to the device, then signals completion with a one-cycle end flag. The device uses that flag to auto-clear its request.

Parameters:
- PRIORITY, 1'b0, constant driven on dma_priority (1 = stall CPU during accesses).

Ports:
- mclk  in  1  main system clock
- reset  in  1  asynchronous, active-high reset
- dev_rqst  in  1  transfer request from device (level)
- dev_rd_wr  in  1  1: memory->device (read); 0: device->memory (write)
- dev_start_address  in  16  byte start address; bit 0 ignored
- dev_num_words  in  16  number of 16-bit words to move
- dev_rdy  in  1  device can accept/produce a word this cycle
- dev_data  in  16  write data from device
- xfer_ack  out  1  one-cycle pulse per completed word, to device dma_ack
- xfer_data  out  16  read word to device, valid while xfer_ack=1
- xfer_end  out  1  one-cycle completion pulse, to device dma_end_flag
- xfer_err  out  1  one-cycle pulse with xfer_end when dma_resp flagged an error
- dma_addr  out  15  memory word address
- dma_din  out  16  memory write data
- dma_en  out  1  memory access request
- dma_we  out  2  byte write enables (2'b11 on write, 2'b00 on read)
- dma_priority  out  1  = PRIORITY
- dma_dout  in  16  memory read data, valid the cycle after acceptance
- dma_ready  in  1  access accepted when dma_en & dma_ready
- dma_resp  in  1  error response, sampled with read data or at write acceptance

Behaviour:
- Reset values: all outputs 0 except dma_priority=PRIORITY. State=IDLE, address/count registers 0, rqst_d=0.
- Start condition: rising edge of dev_rqst (dev_rqst & ~rqst_d, rqst_d registered each cycle).
  - A level held high after completion does not restart a transfer.
- On start, latch cur_addr=dev_start_address & 16'hFFFE, remaining=dev_num_words, dir=dev_rd_wr.
  - Later changes to these inputs are ignored until the next start.
- FSM states: IDLE, WAIT_DEV, MEM_REQ, RD_DATA, DONE.
- IDLE:
  - start with remaining==0 -> DONE; no memory access.
  - start with dir=1 -> MEM_REQ.
  - start with dir=0 -> WAIT_DEV.
- WAIT_DEV (write only): when dev_rdy=1, capture dev_data into dma_din -> MEM_REQ.
- MEM_REQ:
  - dma_en=1, dma_addr=cur_addr[15:1], dma_we=11 for write / 00 for read.
  - Hold all access signals stable until dma_ready=1.
  - On acceptance: read -> RD_DATA.
  - On acceptance: write -> pulse xfer_ack, then apply the post-word step below.
- RD_DATA:
  - Capture dma_dout into xfer_data and pulse xfer_ack in the next cycle.
  - If dev_rdy=0, stay in RD_DATA holding the data until dev_rdy=1.
  - Then apply the post-word step below.
- Post-word step: cur_addr+=2 (16-bit wrap, 0xFFFE->0x0000); remaining-=1.
  - If remaining becomes 0 -> DONE.
  - Otherwise -> WAIT_DEV (write) or MEM_REQ (read).
- DONE: xfer_end=1 for exactly one cycle -> IDLE.
- Latency, read, dev_rdy=1, dma_ready=1: one word per 2 cycles, xfer_ack 2 cycles after dma_en first rises.
- Latency, write, dev_rdy=1, dma_ready=1: one word per 2 cycles.
- Error: dma_resp=1 on any word -> that word is not acked -> DONE with xfer_err=1 together with xfer_end.
- Abort: dev_rqst falls mid-transfer.
  - An outstanding MEM_REQ access completes (dma_en is never dropped before dma_ready).
  - Then -> IDLE with no xfer_ack for a pending read word and no xfer_end.
  - Abort in WAIT_DEV/RD_DATA -> IDLE next cycle.
- Simultaneous events: a rising dev_rqst during DONE is ignored; the device clears its request on xfer_end anyway.
- Reset mid-operation: immediate return to reset values; dma_en drops asynchronously.

Test Plan:
- Read 3 words from 0x0200, dev_rdy=1, dma_ready=1, memory 0x1111/0x2222/0x3333 -> dma_addr 0x100, 0x101, 0x102; xfer_data matches on 3 xfer_ack pulses; single xfer_end 1 cycle after third ack.
- Write 2 words to 0x0301, dev_data 0x7777 -> dma_addr 0x180, 0x181, dma_we=11, dma_din=0x7777; 2 acks, 1 end.
- dma_ready low 4 cycles on word 2 -> dma_en/addr/din held stable throughout; no extra ack; totals unchanged.
- dev_num_words=0 -> xfer_end pulse 2 cycles after start, dma_en never asserted.
- Start 0xFFFE, 2 words read -> dma_addr 0x7FFF then 0x0000; dma_resp=1 on second word -> xfer_end & xfer_err pulse, only 1 ack.
- dev_rqst dropped while in MEM_REQ with dma_ready=0 -> access held until dma_ready, then IDLE, no end pulse. Reset asserted mid-read -> all outputs 0 immediately.

Source files
------------

// File: rtl/simple_dma_controller.sv
// simple_dma_controller: bus-master stage behind the simple DMA device.
// Latches the device request bundle on a rising dev_rqst, then moves one
// 16-bit word at a time over the openMSP430 DMA port. Each completed word
// is acked to the device, and a one-cycle end pulse closes the transfer.
module simple_dma_controller #(
   parameter logic PRIORITY = 1'b0
) (
   input  logic        mclk,
   input  logic        reset,
   // device side
   input  logic        dev_rqst,
   input  logic        dev_rd_wr,
   input  logic [15:0] dev_start_address,
   input  logic [15:0] dev_num_words,
   input  logic        dev_rdy,
   input  logic [15:0] dev_data,
   output logic        xfer_ack,
   output logic [15:0] xfer_data,
   output logic        xfer_end,
   output logic        xfer_err,
   // memory side
   output logic [14:0] dma_addr,
   output logic [15:0] dma_din,
   output logic        dma_en,
   output logic [1:0]  dma_we,
   output logic        dma_priority,
   input  logic [15:0] dma_dout,
   input  logic        dma_ready,
   input  logic        dma_resp
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WAIT_DEV = 3'd1;
   localparam logic [2:0] MEM_REQ  = 3'd2;
   localparam logic [2:0] RD_DATA  = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   logic [2:0]  state;
   logic        rqst_d;
   logic [15:0] cur_addr;
   logic [15:0] remaining;
   logic        dir;        // 1: memory->device
   logic [15:0] din_q;
   logic        rd_held;    // read word already captured, waiting on dev_rdy
   logic        err_q;      // error seen, reported with the end pulse

   logic        start;
   logic        last_word;
   logic [15:0] next_addr;
   logic [15:0] next_rem;

   // Only an edge on the request starts a transfer; a held level does not.
   assign start     = dev_rqst & ~rqst_d;
   assign last_word = (remaining == 16'd1);
   // Byte address steps by one word; wraps naturally at 16 bits.
   assign next_addr = cur_addr + 16'd2;
   assign next_rem  = remaining - 16'd1;

   // Memory port is driven straight from the state so reset drops dma_en at once.
   assign dma_en       = (state == MEM_REQ);
   assign dma_addr     = cur_addr[15:1];
   assign dma_we       = (state == MEM_REQ && !dir) ? 2'b11 : 2'b00;
   assign dma_din      = din_q;
   assign dma_priority = PRIORITY;

   // Request history for edge detection.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) rqst_d <= 1'b0;
      else       rqst_d <= dev_rqst;
   end

   // Transfer sequencer: word loop, per-word ack, error and abort handling.
   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= 16'h0000;
         remaining <= 16'h0000;
         dir       <= 1'b0;
         din_q     <= 16'h0000;
         rd_held   <= 1'b0;
         err_q     <= 1'b0;
         xfer_ack  <= 1'b0;
         xfer_data <= 16'h0000;
         xfer_end  <= 1'b0;
         xfer_err  <= 1'b0;
      end else begin
         xfer_ack <= 1'b0;
         xfer_end <= 1'b0;
         xfer_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur_addr  <= dev_start_address & 16'hFFFE;
                  remaining <= dev_num_words;
                  dir       <= dev_rd_wr;
                  err_q     <= 1'b0;
                  rd_held   <= 1'b0;
                  if (dev_num_words == 16'd0) state <= DONE;
                  else if (dev_rd_wr)         state <= MEM_REQ;
                  else                        state <= WAIT_DEV;
               end
            end
            WAIT_DEV: begin
               if (!dev_rqst) begin
                  state <= IDLE;
               end else if (dev_rdy) begin
                  din_q <= dev_data;
                  state <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               // Never withdraw an access once raised; decide only on acceptance.
               if (dma_ready) begin
                  if (!dev_rqst) begin
                     state <= IDLE;
                  end else if (dir) begin
                     rd_held <= 1'b0;
                     state   <= RD_DATA;
                  end else if (dma_resp) begin
                     err_q <= 1'b1;
                     state <= DONE;
                  end else begin
                     xfer_ack  <= 1'b1;
                     cur_addr  <= next_addr;
                     remaining <= next_rem;
                     state     <= last_word ? DONE : WAIT_DEV;
                  end
               end
            end
            RD_DATA: begin
               if (!dev_rqst) begin
                  state <= IDLE;
               end else if (!rd_held && dma_resp) begin
                  err_q <= 1'b1;
                  state <= DONE;
               end else begin
                  // Read data is only valid in the first cycle; keep it in xfer_data.
                  if (!rd_held) xfer_data <= dma_dout;
                  if (dev_rdy) begin
                     xfer_ack  <= 1'b1;
                     rd_held   <= 1'b0;
                     cur_addr  <= next_addr;
                     remaining <= next_rem;
                     state     <= last_word ? DONE : MEM_REQ;
                  end else begin
                     rd_held <= 1'b1;
                  end
               end
            end
            DONE: begin
               xfer_end <= 1'b1;
               xfer_err <= err_q;
               err_q    <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simple_dma_controller.sv
// Directed bench for simple_dma_controller: a small memory responder with
// programmable stall/error, a negedge monitor logging port activity, and a
// linear sequence of directed transfers checked against hand-computed values.
module tb_simple_dma_controller;

   logic        mclk = 1'b0;
   logic        reset;
   logic        dev_rqst;
   logic        dev_rd_wr;
   logic [15:0] dev_start_address;
   logic [15:0] dev_num_words;
   logic        dev_rdy;
   logic [15:0] dev_data;
   logic        xfer_ack;
   logic [15:0] xfer_data;
   logic        xfer_end;
   logic        xfer_err;
   logic [14:0] dma_addr;
   logic [15:0] dma_din;
   logic        dma_en;
   logic [1:0]  dma_we;
   logic        dma_priority;
   logic [15:0] dma_dout = 16'h0000;
   logic        dma_ready;
   logic        dma_resp;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   simple_dma_controller #(.PRIORITY(1'b0)) dut (
      .mclk(mclk), .reset(reset),
      .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr),
      .dev_start_address(dev_start_address), .dev_num_words(dev_num_words),
      .dev_rdy(dev_rdy), .dev_data(dev_data),
      .xfer_ack(xfer_ack), .xfer_data(xfer_data),
      .xfer_end(xfer_end), .xfer_err(xfer_err),
      .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
      .dma_priority(dma_priority), .dma_dout(dma_dout),
      .dma_ready(dma_ready), .dma_resp(dma_resp)
   );

   always #5 mclk = ~mclk;

   // cycle counter advanced on the active edge, read elsewhere off-edge
   always @(posedge mclk) cyc <= cyc + 1;

   // ---------------- memory responder ----------------
   logic [14:0] stall_addr = 15'h7FFF;
   int          stall_len  = 0;
   int          stall_used = 0;
   logic        err_en     = 1'b0;
   logic [14:0] err_addr   = 15'h0000;
   logic        resp_q     = 1'b0;

   function automatic logic [15:0] rd_fn(input logic [14:0] a);
      case (a)
         15'h0100: rd_fn = 16'h1111;
         15'h0101: rd_fn = 16'h2222;
         15'h0102: rd_fn = 16'h3333;
         15'h7FFF: rd_fn = 16'hBEEF;
         default:  rd_fn = {1'b0, a} ^ 16'h5A5A;
      endcase
   endfunction

   assign dma_ready = !(dma_en && dma_addr == stall_addr && stall_used < stall_len);
   assign dma_resp  = resp_q;

   always @(posedge mclk) begin
      if (dma_en && dma_addr == stall_addr && !dma_ready) stall_used <= stall_used + 1;
      else                                                stall_used <= 0;
      resp_q <= dma_en && dma_ready && dma_we == 2'b00 && err_en && dma_addr == err_addr;
      if (dma_en && dma_ready && dma_we == 2'b00) dma_dout <= rd_fn(dma_addr);
   end

   // ---------------- monitor ----------------
   logic [14:0] acc_addr[$];
   logic [1:0]  acc_we[$];
   logic [15:0] acc_din[$];
   logic [15:0] ack_data[$];
   int          ack_cyc[$];
   int          en_rise[$];
   int          en_cycles = 0, stall_cycles = 0, stab_bad = 0;
   int          end_cnt = 0, end_cyc = 0, err_end = 0, err_alone = 0;
   logic        prev_wait = 1'b0, last_en = 1'b0;
   logic        p_en = 1'b0;
   logic [14:0] p_addr = 15'h0;
   logic [15:0] p_din = 16'h0;
   logic [1:0]  p_we = 2'b0;

   always @(negedge mclk) begin
      if (dma_en) en_cycles <= en_cycles + 1;
      if (dma_en && !dma_ready) stall_cycles <= stall_cycles + 1;
      if (dma_en && !last_en) en_rise.push_back(cyc);
      if (dma_en && dma_ready) begin
         acc_addr.push_back(dma_addr);
         acc_we.push_back(dma_we);
         acc_din.push_back(dma_din);
      end
      if (prev_wait && (dma_en !== p_en || dma_addr !== p_addr ||
                        dma_din !== p_din || dma_we !== p_we))
         stab_bad <= stab_bad + 1;
      prev_wait <= dma_en && !dma_ready;
      p_en      <= dma_en;
      p_addr    <= dma_addr;
      p_din     <= dma_din;
      p_we      <= dma_we;
      last_en   <= dma_en;
      if (xfer_ack) begin
         ack_data.push_back(xfer_data);
         ack_cyc.push_back(cyc);
      end
      if (xfer_end) begin
         end_cnt <= end_cnt + 1;
         end_cyc <= cyc;
         if (xfer_err) err_end <= err_end + 1;
      end
      if (xfer_err && !xfer_end) err_alone <= err_alone + 1;
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge mclk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_end(input int base, input int max);
      int n = 0;
      while (end_cnt == base && n < max) begin
         step(1);
         n++;
      end
      chk("end_seen", 32'(end_cnt), 32'(base + 1));
   endtask

   // hard stop in case something wedges the sequence
   initial begin
      #200000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int a0, k0, e0, r0, c0, en0, st0, sb0, ee0, ea0;
      reset = 1'b1; dev_rqst = 1'b0; dev_rd_wr = 1'b0; dev_start_address = 16'h0;
      dev_num_words = 16'h0; dev_rdy = 1'b0; dev_data = 16'h0;
      step(2);
      chk("rst_dma_en",   32'(dma_en), 32'h0);
      chk("rst_dma_addr", 32'(dma_addr), 32'h0);
      chk("rst_dma_we",   32'(dma_we), 32'h0);
      chk("rst_dma_din",  32'(dma_din), 32'h0);
      chk("rst_xfer",     32'({xfer_ack, xfer_end, xfer_err}), 32'h0);
      chk("rst_xfer_data", 32'(xfer_data), 32'h0);
      chk("rst_priority", 32'(dma_priority), 32'h0);
      reset = 1'b0;
      step(2);

      // read 3 words from 0x0200
      a0 = acc_addr.size(); k0 = ack_data.size(); e0 = end_cnt; r0 = en_rise.size();
      dev_rd_wr = 1'b1; dev_start_address = 16'h0200; dev_num_words = 16'd3;
      dev_rdy = 1'b1; dev_rqst = 1'b1;
      step(1);
      chk("rd_en_first",   32'(dma_en), 32'h1);
      chk("rd_addr_first", 32'(dma_addr), 32'h100);
      chk("rd_we_first",   32'(dma_we), 32'h0);
      wait_end(e0, 30);
      step(4);  // request level still high: must not restart
      chk("rd_acc_cnt", 32'(acc_addr.size() - a0), 32'd3);
      chk("rd_addr1",   32'(acc_addr[a0+1]), 32'h101);
      chk("rd_addr2",   32'(acc_addr[a0+2]), 32'h102);
      chk("rd_ack_cnt", 32'(ack_data.size() - k0), 32'd3);
      chk("rd_data0",   32'(ack_data[k0]),   32'h1111);
      chk("rd_data1",   32'(ack_data[k0+1]), 32'h2222);
      chk("rd_data2",   32'(ack_data[k0+2]), 32'h3333);
      chk("rd_ack_lat", 32'(ack_cyc[k0] - en_rise[r0]), 32'd2);
      chk("rd_rate",    32'(ack_cyc[k0+1] - ack_cyc[k0]), 32'd2);
      chk("rd_end_lat", 32'(end_cyc - ack_cyc[k0+2]), 32'd1);
      chk("rd_end_once", 32'(end_cnt), 32'(e0 + 1));
      dev_rqst = 1'b0;
      step(2);

      // write 2 words to 0x0301
      a0 = acc_addr.size(); k0 = ack_data.size(); e0 = end_cnt;
      dev_rd_wr = 1'b0; dev_start_address = 16'h0301; dev_num_words = 16'd2;
      dev_data = 16'h7777; dev_rqst = 1'b1;
      wait_end(e0, 30);
      step(2);
      chk("wr_acc_cnt", 32'(acc_addr.size() - a0), 32'd2);
      chk("wr_addr0",   32'(acc_addr[a0]),   32'h180);
      chk("wr_addr1",   32'(acc_addr[a0+1]), 32'h181);
      chk("wr_we0",     32'(acc_we[a0]),     32'h3);
      chk("wr_we1",     32'(acc_we[a0+1]),   32'h3);
      chk("wr_din0",    32'(acc_din[a0]),    32'h7777);
      chk("wr_din1",    32'(acc_din[a0+1]),  32'h7777);
      chk("wr_ack_cnt", 32'(ack_data.size() - k0), 32'd2);
      chk("wr_rate",    32'(ack_cyc[k0+1] - ack_cyc[k0]), 32'd2);
      chk("wr_end_once", 32'(end_cnt), 32'(e0 + 1));
      dev_rqst = 1'b0;
      step(2);

      // write 3 words, memory stalls 4 cycles on word 2
      a0 = acc_addr.size(); k0 = ack_data.size(); e0 = end_cnt;
      st0 = stall_cycles; sb0 = stab_bad;
      stall_addr = 15'h201; stall_len = 4;
      dev_start_address = 16'h0400; dev_num_words = 16'd3; dev_data = 16'hA5A5;
      dev_rqst = 1'b1;
      wait_end(e0, 40);
      step(2);
      chk("st_stalls",   32'(stall_cycles - st0), 32'd4);
      chk("st_stable",   32'(stab_bad), 32'(sb0));
      chk("st_acc_cnt",  32'(acc_addr.size() - a0), 32'd3);
      chk("st_addr1",    32'(acc_addr[a0+1]), 32'h201);
      chk("st_din1",     32'(acc_din[a0+1]), 32'hA5A5);
      chk("st_ack_cnt",  32'(ack_data.size() - k0), 32'd3);
      chk("st_end_once", 32'(end_cnt), 32'(e0 + 1));
      dev_rqst = 1'b0; stall_len = 0;
      step(2);

      // zero-length transfer
      k0 = ack_data.size(); e0 = end_cnt; en0 = en_cycles;
      dev_rd_wr = 1'b1; dev_num_words = 16'd0; c0 = cyc;
      dev_rqst = 1'b1;
      wait_end(e0, 10);
      chk("z_end_lat", 32'(end_cyc - c0), 32'd2);
      chk("z_no_en",   32'(en_cycles), 32'(en0));
      chk("z_no_ack",  32'(ack_data.size()), 32'(k0));
      dev_rqst = 1'b0;
      step(2);

      // read 2 words from 0xFFFE, error on the wrapped second word
      a0 = acc_addr.size(); k0 = ack_data.size(); e0 = end_cnt;
      ee0 = err_end; ea0 = err_alone;
      err_en = 1'b1; err_addr = 15'h0000;
      dev_start_address = 16'hFFFE; dev_num_words = 16'd2; dev_rqst = 1'b1;
      wait_end(e0, 30);
      step(2);
      chk("wrap_addr0", 32'(acc_addr[a0]),   32'h7FFF);
      chk("wrap_addr1", 32'(acc_addr[a0+1]), 32'h0000);
      chk("err_ack_cnt", 32'(ack_data.size() - k0), 32'd1);
      chk("err_data0",  32'(ack_data[k0]), 32'hBEEF);
      chk("err_with_end", 32'(err_end - ee0), 32'd1);
      chk("err_alone",  32'(err_alone), 32'(ea0));
      dev_rqst = 1'b0; err_en = 1'b0;
      step(2);

      // abort while the access is waiting on dma_ready
      a0 = acc_addr.size(); k0 = ack_data.size(); e0 = end_cnt; sb0 = stab_bad;
      stall_addr = 15'h280; stall_len = 3;
      dev_start_address = 16'h0500; dev_num_words = 16'd2; dev_rqst = 1'b1;
      step(1);
      chk("ab_en_up", 32'(dma_en), 32'h1);
      dev_rqst = 1'b0;
      step(1);
      chk("ab_en_held", 32'(dma_en), 32'h1);
      step(8);
      chk("ab_acc_cnt", 32'(acc_addr.size() - a0), 32'd1);
      chk("ab_acc_addr", 32'(acc_addr[a0]), 32'h280);
      chk("ab_no_ack",  32'(ack_data.size()), 32'(k0));
      chk("ab_no_end",  32'(end_cnt), 32'(e0));
      chk("ab_idle",    32'(dma_en), 32'h0);
      chk("ab_stable",  32'(stab_bad), 32'(sb0));
      stall_len = 0;
      step(2);

      // reset in the middle of a read
      dev_start_address = 16'h0600; dev_num_words = 16'd4; dev_rqst = 1'b1;
      step(1);
      chk("mr_en_up", 32'(dma_en), 32'h1);
      #2 reset = 1'b1;
      #1;
      chk("mr_en",   32'(dma_en), 32'h0);
      chk("mr_addr", 32'(dma_addr), 32'h0);
      chk("mr_din",  32'(dma_din), 32'h0);
      chk("mr_xfer", 32'({xfer_ack, xfer_end, xfer_err}), 32'h0);
      dev_rqst = 1'b0;
      step(2);
      reset = 1'b0;
      step(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
